// File: rtl/boot_loader.sv
// Streams a program into SRAM from address 0, then starts the CPU and waits for it to return idle.
// Writes are combinational with the stream handshake; s_ready drops when the SRAM is full or outside LOAD.
module boot_loader #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic              ap_clk,
    input  logic              ap_rst,
    input  logic              go,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_last,
    output logic              cpu_start,
    input  logic              cpu_idle,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic              cpu_ce,
    input  logic              cpu_we,
    input  logic [DATA_W-1:0] cpu_d,
    input  logic [3:0]        cpu_strb,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_din,
    output logic [3:0]        sram_wea,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   word_count,
    output logic [31:0]       run_cycles
);

    typedef enum logic [2:0] {IDLE, LOAD, START, RUN, DONE} state_t;

    localparam logic [ADDR_W:0] CAP      = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] LAST_ADR = CAP - 1'b1;

    state_t state, state_nxt;
    logic   hs;
    logic   restart;
    logic   fill_no_last;

    assign s_ready      = (state == LOAD) && (word_count < CAP);
    assign hs           = s_valid & s_ready;
    assign restart      = ((state == IDLE) || (state == DONE)) && go;
    assign fill_no_last = hs && !s_last && (word_count == LAST_ADR);
    assign cpu_start    = (state == START);
    assign busy         = (state == LOAD) || (state == START) || (state == RUN);
    assign done         = (state == DONE);

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        sram_addr = word_count[ADDR_W-1:0];
        sram_din  = '0;
        sram_wea  = 4'h0;
        case (state)
            IDLE, DONE: begin
                if (go) state_nxt = LOAD;
            end
            LOAD: begin
                if (hs) begin
                    sram_din = s_data;
                    sram_wea = 4'hF;
                    // s_last takes priority over the overflow exit when both hit on the final address
                    if (s_last)            state_nxt = START;
                    else if (fill_no_last) state_nxt = DONE;
                end
            end
            START, RUN: begin
                sram_addr = cpu_addr;
                sram_din  = cpu_d;
                sram_wea  = {4{cpu_we & cpu_ce}} & cpu_strb;
                if (state == START) begin
                    if (!cpu_idle) state_nxt = RUN;
                end else if (cpu_idle) begin
                    state_nxt = DONE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            word_count <= '0;
            run_cycles <= '0;
            err        <= 1'b0;
        end else if (restart) begin
            word_count <= '0;
            run_cycles <= '0;
            err        <= 1'b0;
        end else begin
            if (hs)           word_count <= word_count + 1'b1;
            if (fill_no_last) err        <= 1'b1;
            if (state == RUN && run_cycles != 32'hFFFF_FFFF)
                run_cycles <= run_cycles + 32'd1;
        end
    end

endmodule

// File: tb/tb_boot_loader.sv
// Directed bench for boot_loader: a default-size instance and an 8-word instance share stimulus.
module tb_boot_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        go = 1'b0;
    logic        s_valid = 1'b0;
    logic [31:0] s_data = '0;
    logic        s_last = 1'b0;
    logic        cpu_idle = 1'b1;
    logic [9:0]  cpu_addr = '0;
    logic        cpu_ce = 1'b0;
    logic        cpu_we = 1'b0;
    logic [31:0] cpu_d = '0;
    logic [3:0]  cpu_strb = '0;

    logic        s_ready, cpu_start, busy, done, err;
    logic [9:0]  sram_addr;
    logic [31:0] sram_din, run_cycles;
    logic [3:0]  sram_wea;
    logic [10:0] word_count;

    logic        s_ready_s, cpu_start_s, busy_s, done_s, err_s;
    logic [2:0]  sram_addr_s;
    logic [31:0] sram_din_s, run_cycles_s;
    logic [3:0]  sram_wea_s;
    logic [3:0]  word_count_s;

    int total = 0;
    int bad = 0;
    logic [31:0] wa[$];
    logic [31:0] wd[$];
    logic [3:0]  ww[$];
    logic [31:0] wa_s[$];
    logic        start_s_seen = 1'b0;

    always #5 clk = ~clk;

    boot_loader dut (
        .ap_clk(clk), .ap_rst(rst), .go(go),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
        .cpu_start(cpu_start), .cpu_idle(cpu_idle),
        .cpu_addr(cpu_addr), .cpu_ce(cpu_ce), .cpu_we(cpu_we), .cpu_d(cpu_d), .cpu_strb(cpu_strb),
        .sram_addr(sram_addr), .sram_din(sram_din), .sram_wea(sram_wea),
        .busy(busy), .done(done), .err(err), .word_count(word_count), .run_cycles(run_cycles)
    );

    boot_loader #(.ADDR_W(3)) dut_s (
        .ap_clk(clk), .ap_rst(rst), .go(go),
        .s_valid(s_valid), .s_ready(s_ready_s), .s_data(s_data), .s_last(s_last),
        .cpu_start(cpu_start_s), .cpu_idle(cpu_idle),
        .cpu_addr(cpu_addr[2:0]), .cpu_ce(cpu_ce), .cpu_we(cpu_we), .cpu_d(cpu_d), .cpu_strb(cpu_strb),
        .sram_addr(sram_addr_s), .sram_din(sram_din_s), .sram_wea(sram_wea_s),
        .busy(busy_s), .done(done_s), .err(err_s), .word_count(word_count_s), .run_cycles(run_cycles_s)
    );

    always @(negedge clk) begin
        #2;
        if (sram_wea != 4'h0) begin
            wa.push_back(32'(sram_addr));
            wd.push_back(sram_din);
            ww.push_back(sram_wea);
        end
        if (sram_wea_s != 4'h0) wa_s.push_back(32'(sram_addr_s));
        if (cpu_start_s) start_s_seen = 1'b1;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [31:0] d, input logic l);
        @(negedge clk);
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic do_go();
        @(negedge clk);
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        wa.delete(); wd.delete(); ww.delete(); wa_s.delete();
    endtask

    // Called right after the edge that enters START; the CPU holds idle low for n RUN cycles.
    task automatic run_cpu(input int n);
        @(negedge clk);
        #1;
        chk("start_high", 64'(cpu_start), 64'd1);
        cpu_idle = 1'b0;
        @(posedge clk);
        repeat (n) @(posedge clk);
        @(negedge clk);
        cpu_idle = 1'b1;
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("run_done", 64'(done), 64'd1);
        chk("run_cycles", 64'(run_cycles), 64'(n + 1));
        chk("run_start_low", 64'(cpu_start), 64'd0);
    endtask

    initial begin
        // Reset mid-cycle with s_valid already high
        s_valid = 1'b1;
        s_data  = 32'hDEAD_BEEF;
        #2 rst = 1'b1;
        #1;
        chk("rst_ready", 64'(s_ready), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_start", 64'(cpu_start), 64'd0);
        chk("rst_wea", 64'(sram_wea), 64'd0);
        chk("rst_wc", 64'(word_count), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_runc", 64'(run_cycles), 64'd0);
        chk("rst_addr", 64'(sram_addr), 64'd0);
        chk("rst_din", 64'(sram_din), 64'd0);
        @(negedge clk);
        s_valid = 1'b0;
        rst = 1'b0;

        // Back-to-back load of four words
        do_go();
        chk("load_busy", 64'(busy), 64'd1);
        for (int i = 0; i < 4; i++) send(32'h11 * (i + 1), i == 3);
        chk("b2b_wc", 64'(word_count), 64'd4);
        chk("b2b_nwr", 64'(wa.size()), 64'd4);
        for (int i = 0; i < wa.size(); i++) begin
            chk("b2b_addr", 64'(wa[i]), 64'(i));
            chk("b2b_data", 64'(wd[i]), 64'(32'h11 * (i + 1)));
            chk("b2b_wea", 64'(ww[i]), 64'hF);
        end
        run_cpu(0);

        // Reload from DONE with a gapped stream and a long CPU run
        do_go();
        chk("reload_wc", 64'(word_count), 64'd0);
        chk("reload_runc", 64'(run_cycles), 64'd0);
        chk("reload_done", 64'(done), 64'd0);
        send(32'hA0, 1'b0);
        @(posedge clk);
        send(32'hA1, 1'b0);
        @(posedge clk);
        @(posedge clk);
        send(32'hA2, 1'b1);
        chk("gap_wc", 64'(word_count), 64'd3);
        chk("gap_nwr", 64'(wa.size()), 64'd3);
        for (int i = 0; i < wa.size(); i++) begin
            chk("gap_addr", 64'(wa[i]), 64'(i));
            chk("gap_data", 64'(wd[i]), 64'(32'hA0 + i));
        end
        fork
            run_cpu(100);
            begin
                repeat (20) @(negedge clk);
                cpu_addr = 10'd5; cpu_d = 32'h1234_ABCD;
                cpu_we = 1'b1; cpu_ce = 1'b1; cpu_strb = 4'b0011;
                #1;
                chk("cpu_wea", 64'(sram_wea), 64'h3);
                chk("cpu_addr", 64'(sram_addr), 64'd5);
                chk("cpu_din", 64'(sram_din), 64'h1234_ABCD);
                @(negedge clk);
                cpu_we = 1'b0; cpu_ce = 1'b0; cpu_strb = 4'b0000;
            end
        join
        chk("gap_err", 64'(err), 64'd0);

        // Reset during RUN, then a fresh two-word load
        do_go();
        send(32'h55, 1'b0);
        send(32'h66, 1'b1);
        @(negedge clk);
        cpu_idle = 1'b0;
        repeat (5) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("rrun_start", 64'(cpu_start), 64'd0);
        chk("rrun_busy", 64'(busy), 64'd0);
        chk("rrun_done", 64'(done), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        cpu_idle = 1'b1;
        do_go();
        send(32'h77, 1'b0);
        send(32'h88, 1'b1);
        chk("rl_wc", 64'(word_count), 64'd2);
        chk("rl_nwr", 64'(wa.size()), 64'd2);
        if (wa.size() == 2) begin
            chk("rl_addr0", 64'(wa[0]), 64'd0);
            chk("rl_addr1", 64'(wa[1]), 64'd1);
        end
        run_cpu(3);

        // Overflow on the 8-word instance: nine words, no s_last
        do_go();
        start_s_seen = 1'b0;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            s_valid = 1'b1;
            s_data  = 32'h100 + i;
            #1;
            if (i == 8) chk("ovf_ready9", 64'(s_ready_s), 64'd0);
            @(posedge clk);
            #1;
            s_valid = 1'b0;
        end
        @(negedge clk);
        #1;
        chk("ovf_err", 64'(err_s), 64'd1);
        chk("ovf_done", 64'(done_s), 64'd1);
        chk("ovf_wc", 64'(word_count_s), 64'd8);
        chk("ovf_nwr", 64'(wa_s.size()), 64'd8);
        for (int i = 0; i < wa_s.size(); i++) chk("ovf_addr", 64'(wa_s[i]), 64'(i));
        chk("ovf_nostart", 64'(start_s_seen), 64'd0);

        // s_last together with the final address: START, no error
        do_go();
        for (int i = 0; i < 8; i++) send(32'h200 + i, i == 7);
        chk("fill_start", 64'(cpu_start_s), 64'd1);
        chk("fill_err", 64'(err_s), 64'd0);
        chk("fill_wc", 64'(word_count_s), 64'd8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
